// File: rtl/learn_pkg.sv
// learn_pkg: state and sign encodings shared by the perceptron training controller
package learn_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LOAD,
    S_EVAL,
    S_EPOCH_END,
    S_DONE
  } state_e;
  localparam logic [1:0] SGN_POS  = 2'b01;
  localparam logic [1:0] SGN_NEG  = 2'b11;
  localparam logic [1:0] SGN_SKIP = 2'b00;
  function automatic logic is_miss(input logic [1:0] t, input logic [1:0] s);
    return (t == SGN_POS || t == SGN_NEG) && s != t;
  endfunction
endpackage

// File: rtl/learn_sat_counter.sv
// learn_sat_counter: clearable up-counter that sticks at its maximum value
module learn_sat_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst || clr_i) cnt_q <= '0;
    else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/perceptron_train_ctrl.sv
// perceptron_train_ctrl: epoch sequencer driving a two-input perceptron learning datapath
module perceptron_train_ctrl
  import learn_pkg::*;
#(
  parameter int AW        = 4,
  parameter int MAX_EPOCH = 64,
  parameter int EW        = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW:0]   sample_count_i,
  input  logic [1:0]    t_in_i,
  input  logic [1:0]    sign_yin_i,
  output logic          mem_rd_en_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          dp_clear_o,
  output logic          dp_load_o,
  output logic          dp_update_o,
  output logic          busy_o,
  output logic          ready_o,
  output logic          converged_o,
  output logic          timeout_o,
  output logic [EW-1:0] epoch_cnt_o,
  output logic [EW-1:0] err_cnt_o
);
  state_e        state_q;
  logic [AW:0]   cnt_q;
  logic [AW-1:0] idx_q;
  logic          go, last, conv, tmo, err_inc, err_clr, ep_inc;
  assign go      = start_i && (state_q == S_IDLE || state_q == S_DONE);
  assign last    = {1'b0, idx_q} == cnt_q - 1'b1;
  assign conv    = err_cnt_o == '0;
  assign tmo     = epoch_cnt_o == EW'(MAX_EPOCH - 1);
  assign err_inc = state_q == S_EVAL && is_miss(t_in_i, sign_yin_i);
  assign err_clr = go || (state_q == S_EPOCH_END && !conv && !tmo);
  assign ep_inc  = state_q == S_EPOCH_END;
  assign dp_update_o = err_inc;
  learn_sat_counter #(.W(EW)) u_err (
    .clk(clk), .rst(rst), .clr_i(err_clr), .inc_i(err_inc), .cnt_o(err_cnt_o)
  );
  learn_sat_counter #(.W(EW)) u_epoch (
    .clk(clk), .rst(rst), .clr_i(go), .inc_i(ep_inc), .cnt_o(epoch_cnt_o)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      mem_rd_en_o <= 1'b0;
      mem_addr_o  <= '0;
      dp_clear_o  <= 1'b0;
      dp_load_o   <= 1'b0;
      busy_o      <= 1'b0;
      ready_o     <= 1'b0;
      converged_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      mem_rd_en_o <= 1'b0;
      dp_clear_o  <= 1'b0;
      dp_load_o   <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: if (start_i) begin
          cnt_q       <= sample_count_i;
          converged_o <= 1'b0;
          timeout_o   <= 1'b0;
          ready_o     <= sample_count_i == '0;
          busy_o      <= sample_count_i != '0;
          dp_clear_o  <= sample_count_i != '0;
          state_q     <= sample_count_i == '0 ? S_DONE : S_CLEAR;
        end
        S_CLEAR: begin
          idx_q       <= '0;
          mem_rd_en_o <= 1'b1;
          mem_addr_o  <= '0;
          state_q     <= S_FETCH;
        end
        S_FETCH: begin
          dp_load_o <= 1'b1;
          state_q   <= S_LOAD;
        end
        S_LOAD: state_q <= S_EVAL;
        S_EVAL: if (last) state_q <= S_EPOCH_END;
        else begin
          idx_q       <= idx_q + 1'b1;
          mem_rd_en_o <= 1'b1;
          mem_addr_o  <= idx_q + 1'b1;
          state_q     <= S_FETCH;
        end
        S_EPOCH_END: if (conv || tmo) begin
          converged_o <= conv;
          timeout_o   <= !conv;
          ready_o     <= 1'b1;
          busy_o      <= 1'b0;
          state_q     <= S_DONE;
        end else begin
          idx_q       <= '0;
          mem_rd_en_o <= 1'b1;
          mem_addr_o  <= '0;
          state_q     <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// tb_perceptron_train_ctrl: directed checks of the training sequencer against a behavioural datapath
module tb_perceptron_train_ctrl;
  localparam int AW = 4;
  localparam int EW = 7;
  localparam int ME = 5;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   sample_count = '0;
  logic [1:0]    t_in, sign_yin;
  logic          mem_rd_en, dp_clear, dp_load, dp_update, busy, ready, converged, timeout;
  logic [AW-1:0] mem_addr;
  logic [EW-1:0] epoch_cnt, err_cnt;
  int checks = 0;
  int errors = 0;
  int n_clr = 0, n_load = 0, n_upd = 0, n_rd = 0;
  bit viol = 0;
  int mx1 [16];
  int mx2 [16];
  logic [1:0] mt [16];
  logic [AW-1:0] rd_addr = '0;
  int w1 = 0, w2 = 0, b = 0, lx1 = 0, lx2 = 0, lt = 0;
  perceptron_train_ctrl #(.AW(AW), .MAX_EPOCH(ME), .EW(EW)) dut (
    .clk(clk), .rst(rst), .start_i(start), .sample_count_i(sample_count),
    .t_in_i(t_in), .sign_yin_i(sign_yin), .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr),
    .dp_clear_o(dp_clear), .dp_load_o(dp_load), .dp_update_o(dp_update), .busy_o(busy),
    .ready_o(ready), .converged_o(converged), .timeout_o(timeout),
    .epoch_cnt_o(epoch_cnt), .err_cnt_o(err_cnt)
  );
  always #5 clk = ~clk;
  function automatic int tval(input logic [1:0] t);
    return t == 2'b01 ? 1 : t == 2'b11 ? -1 : 0;
  endfunction
  assign t_in = mt[rd_addr];
  assign sign_yin = (b + w1 * lx1 + w2 * lx2) > 0 ? 2'b01 : 2'b11;
  always @(posedge clk) begin
    if (mem_rd_en) rd_addr <= mem_addr;
    if (dp_clear) begin
      w1 <= 0; w2 <= 0; b <= 0;
    end else if (dp_update) begin
      w1 <= w1 + lx1 * lt; w2 <= w2 + lx2 * lt; b <= b + lt;
    end
    if (dp_load) begin
      lx1 <= mx1[rd_addr]; lx2 <= mx2[rd_addr]; lt <= tval(mt[rd_addr]);
    end
  end
  always @(negedge clk) begin
    n_clr  <= n_clr + int'(dp_clear);
    n_load <= n_load + int'(dp_load);
    n_upd  <= n_upd + int'(dp_update);
    n_rd   <= n_rd + int'(mem_rd_en);
    if ($countones({dp_clear, dp_load, dp_update, mem_rd_en}) > 1 || (converged && timeout)) viol = 1;
  end
  function automatic int ref_epochs(input int n, input int maxe, output bit conv);
    int a1, a2, ab, errs, y, s, tv;
    a1 = 0; a2 = 0; ab = 0; conv = 0;
    for (int e = 1; e <= maxe; e++) begin
      errs = 0;
      for (int i = 0; i < n; i++) begin
        tv = tval(mt[i]);
        y = ab + a1 * mx1[i] + a2 * mx2[i];
        s = y > 0 ? 1 : -1;
        if (tv != 0 && s != tv) begin
          a1 += mx1[i] * tv; a2 += mx2[i] * tv; ab += tv; errs++;
        end
      end
      if (errs == 0) begin
        conv = 1;
        return e;
      end
    end
    return maxe;
  endfunction
  task automatic set4(input int a0, input int b0, input logic [1:0] t0, input int a1, input int b1, input logic [1:0] t1,
                      input int a2, input int b2, input logic [1:0] t2, input int a3, input int b3, input logic [1:0] t3);
    mx1[0] = a0; mx2[0] = b0; mt[0] = t0;
    mx1[1] = a1; mx2[1] = b1; mt[1] = t1;
    mx1[2] = a2; mx2[2] = b2; mt[2] = t2;
    mx1[3] = a3; mx2[3] = b3; mt[3] = t3;
  endtask
  task automatic load_and();
    set4(1, 1, 2'b01, 1, -1, 2'b11, -1, 1, 2'b11, -1, -1, 2'b11);
  endtask
  task automatic start_run(input int n);
    @(negedge clk);
    n_clr = 0; n_load = 0; n_upd = 0; n_rd = 0;
    sample_count = (AW+1)'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_ready(input int k0, output int k);
    k = k0;
    while (!ready && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL wait_ready: ready=%0b after %0d cycles, required 1", ready, k);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({mem_rd_en, mem_addr, dp_clear, dp_load, dp_update, busy, ready, converged, timeout, epoch_cnt, err_cnt} !== '0) begin
      errors++;
      $display("FAIL %s: outputs rd=%0b addr=%0d clr=%0b ld=%0b upd=%0b busy=%0b rdy=%0b conv=%0b to=%0b ep=%0d err=%0d, required all 0",
               tag, mem_rd_en, mem_addr, dp_clear, dp_load, dp_update, busy, ready, converged, timeout, epoch_cnt, err_cnt);
    end
  endtask
  task automatic check_run(input string tag, input int k, input int k_exp, input int ep_exp, input bit conv_exp,
                           input int loads_exp, input int upd_exp);
    checks++;
    if (k !== k_exp) begin
      errors++;
      $display("FAIL %s latency: ready at cycle %0d, required %0d", tag, k, k_exp);
    end
    checks++;
    if (epoch_cnt !== EW'(ep_exp)) begin
      errors++;
      $display("FAIL %s epoch_cnt: got %0d, required %0d", tag, epoch_cnt, ep_exp);
    end
    checks++;
    if ({converged, timeout, busy} !== {conv_exp, ~conv_exp, 1'b0}) begin
      errors++;
      $display("FAIL %s flags: conv=%0b to=%0b busy=%0b, required conv=%0b to=%0b busy=0",
               tag, converged, timeout, busy, conv_exp, ~conv_exp);
    end
    checks++;
    if (n_clr !== 1 || n_load !== loads_exp || n_rd !== loads_exp) begin
      errors++;
      $display("FAIL %s strobes: clr=%0d load=%0d rd=%0d, required clr=1 load=%0d rd=%0d",
               tag, n_clr, n_load, n_rd, loads_exp, loads_exp);
    end
    if (upd_exp >= 0) begin
      checks++;
      if (n_upd !== upd_exp) begin
        errors++;
        $display("FAIL %s updates: got %0d, required %0d", tag, n_upd, upd_exp);
      end
    end
  endtask
  task automatic test_reset();
    int k, clr_before;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_initial");
    @(negedge clk);
    rst = 1'b0;
    load_and();
    start_run(4);
    repeat (6) @(posedge clk);
    @(negedge clk);
    clr_before = n_clr;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_midrun");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (n_clr !== clr_before) begin
      errors++;
      $display("FAIL reset_no_clear: dp_clear pulses %0d, required %0d", n_clr, clr_before);
    end
    start_run(4);
    checks++;
    if ({dp_clear, busy} !== 2'b11) begin
      errors++;
      $display("FAIL reset_restart: clr=%0b busy=%0b, required 1 1", dp_clear, busy);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (dp_load !== 1'b1) begin
      errors++;
      $display("FAIL first_load: dp_load=%0b at cycle 3, required 1", dp_load);
    end
    wait_ready(3, k);
    check_run("reset_rerun", k, 28, 2, 1'b1, 8, 3);
  endtask
  task automatic test_and();
    int k, e;
    bit c;
    load_and();
    e = ref_epochs(4, ME, c);
    start_run(4);
    wait_ready(1, k);
    check_run("and", k, 2 + e * 13, e, c, e * 4, 3);
    checks++;
    if (err_cnt !== '0) begin
      errors++;
      $display("FAIL and err_cnt: got %0d, required 0", err_cnt);
    end
  endtask
  task automatic test_xor();
    int k;
    set4(1, 1, 2'b11, 1, -1, 2'b01, -1, 1, 2'b01, -1, -1, 2'b11);
    start_run(4);
    wait_ready(1, k);
    check_run("xor", k, 67, 5, 1'b0, 20, -1);
  endtask
  task automatic test_zero_count();
    int k;
    start_run(0);
    wait_ready(1, k);
    checks++;
    if (k !== 1 || {converged, timeout, busy} !== 3'b000 || n_clr !== 0 || n_load !== 0) begin
      errors++;
      $display("FAIL zero_count: k=%0d conv=%0b to=%0b busy=%0b clr=%0d load=%0d, required k=1 flags 0 pulses 0",
               k, converged, timeout, busy, n_clr, n_load);
    end
  endtask
  task automatic test_skip();
    int k;
    set4(1, 1, 2'b00, 1, -1, 2'b00, -1, 1, 2'b00, -1, -1, 2'b00);
    start_run(3);
    wait_ready(1, k);
    check_run("skip", k, 12, 1, 1'b1, 3, 0);
  endtask
  task automatic test_back_to_back();
    int k;
    load_and();
    start_run(4);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ready(7, k);
    check_run("start_ignored", k, 28, 2, 1'b1, 8, 3);
    @(negedge clk);
    n_clr = 0; n_load = 0; n_upd = 0; n_rd = 0;
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ready, busy, dp_clear, converged} !== 4'b0110 || epoch_cnt !== '0) begin
      errors++;
      $display("FAIL restart_from_done: rdy=%0b busy=%0b clr=%0b conv=%0b ep=%0d, required 0 1 1 0 ep=0",
               ready, busy, dp_clear, converged, epoch_cnt);
    end
    @(negedge clk);
    start = 1'b0;
    wait_ready(1, k);
    check_run("restart_run", k, 28, 2, 1'b1, 8, 3);
  endtask
  initial begin
    test_reset();
    test_and();
    test_xor();
    test_zero_count();
    test_skip();
    test_back_to_back();
    checks++;
    if (viol) begin
      errors++;
      $display("FAIL exclusivity: strobe overlap or converged&timeout seen=%0b, required 0", viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
